// File: rtl/mips_pkg.sv
// Shared types for the MIPS multiply hazard logic: in-flight multiply slot
// record and the slot index whose retire cycle matches an ALU write-back.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
    } mult_slot_t;

    // Slot K retires in the same cycle an ALU op issued now writes back.
    function automatic int unsigned wport_slot_idx(input int unsigned mult_lat,
                                                   input int unsigned alu_wb_dly);
        return mult_lat - 1 - alu_wb_dly;
    endfunction

endpackage

// File: rtl/mips_mult_slot_pipe.sv
// Non-stalling shift pipeline of in-flight multiply destinations; slot[0] is
// loaded every cycle and slot[MULT_LAT-1] is the entry retiring this cycle.
module mips_mult_slot_pipe
    import mips_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  mult_slot_t load_slot,
    output mult_slot_t slots [MULT_LAT]
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MULT_LAT; i++) begin
                slots[i] <= '0;
            end
        end else begin
            slots[0] <= load_slot;
            for (int unsigned i = 1; i < MULT_LAT; i++) begin
                slots[i] <= slots[i-1];
            end
        end
    end

endmodule

// File: rtl/mips_mult_hazard_unit.sv
// Decode-stage hazard unit for a fixed-latency pipelined multiplier: RAW and
// write-port stalls, optional WAW stall (MIPS_MULT_WAW_EN), stall counter.
module mips_mult_hazard_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MULT_LAT   = 4,
    parameter int unsigned ALU_WB_DLY = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid_D,
    input  logic                  mult_start_D,
    input  logic                  RegWrite_D,
    input  logic [REG_ADDR_W-1:0] reg_src_a_addr_D,
    input  logic [REG_ADDR_W-1:0] reg_src_b_addr_D,
    input  logic [REG_ADDR_W-1:0] reg_dest_addr_D,
    output logic                  stall,
    output logic                  stall_raw,
    output logic                  stall_wport,
    output logic                  mult_busy,
    output logic [CNT_W-1:0]      stall_cnt
`ifdef MIPS_MULT_WAW_EN
    ,
    output logic                  stall_waw
`endif
);

    import mips_pkg::*;

    localparam int unsigned K = wport_slot_idx(MULT_LAT, ALU_WB_DLY);

    mult_slot_t       slots [MULT_LAT];
    mult_slot_t       load_slot;
    logic             raw_hit;
    logic             busy_any;
    logic [CNT_W-1:0] cnt_q;

    mips_mult_slot_pipe #(
        .MULT_LAT (MULT_LAT)
    ) u_slot_pipe (
        .clk       (clk),
        .rst_n     (rst),
        .load_slot (load_slot),
        .slots     (slots)
    );

    // The last slot writes this cycle; write-before-read makes it hazard-free.
    always_comb begin
        raw_hit  = 1'b0;
        busy_any = 1'b0;
        for (int unsigned j = 0; j < MULT_LAT; j++) begin
            busy_any = busy_any | slots[j].valid;
            if (slots[j].valid && (j != MULT_LAT - 1)) begin
                if ((reg_src_a_addr_D != '0) && (slots[j].dest == reg_src_a_addr_D)) begin
                    raw_hit = 1'b1;
                end
                if ((reg_src_b_addr_D != '0) && (slots[j].dest == reg_src_b_addr_D)) begin
                    raw_hit = 1'b1;
                end
            end
        end
    end

    assign stall_raw   = rst & issue_valid_D & raw_hit;
    assign stall_wport = rst & issue_valid_D & RegWrite_D & ~mult_start_D & slots[K].valid;
    assign mult_busy   = rst & busy_any;

`ifdef MIPS_MULT_WAW_EN
    logic waw_hit;

    // Slots below K retire after an ALU op issued now would write.
    always_comb begin
        waw_hit = 1'b0;
        for (int unsigned j = 0; j < K; j++) begin
            if (slots[j].valid && (slots[j].dest == reg_dest_addr_D)) begin
                waw_hit = 1'b1;
            end
        end
    end

    assign stall_waw = rst & issue_valid_D & RegWrite_D & ~mult_start_D
                       & (reg_dest_addr_D != '0) & waw_hit;
    assign stall     = stall_raw | stall_wport | stall_waw;
`else
    assign stall     = stall_raw | stall_wport;
`endif

    always_comb begin
        load_slot       = '0;
        load_slot.valid = issue_valid_D & mult_start_D & ~stall;
        if (load_slot.valid) begin
            load_slot.dest = reg_dest_addr_D;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;

endmodule
